inversion_point_gen: RTL and testbench

INVERSION_POINT_GEN -- requirements
Module: inversion_point_gen

---
 rtl/ga_pkg.sv | 22 ++
 rtl/inversion_point_gen_lfsr16.sv | 29 ++
 rtl/inversion_point_gen.sv | 158 +++++++++++++++
 tb/tb_inversion_point_gen.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga_pkg.sv
// Shared definitions for the GA inversion-point generator: default sizes,
// LFSR constants, the draw FSM state type and the LFSR step function.
package ga_pkg;

  localparam int          GA_CHROM_LEN      = 150;
  localparam int          GA_IDX_W          = 8;
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  typedef enum logic [1:0] {
    DRAW_A = 2'd0,
    DRAW_B = 2'd1,
    CHECK  = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // One right-shifting Galois step: the bit shifted out folds the taps back in.
  function automatic logic [15:0] lfsr_advance(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/inversion_point_gen_lfsr16.sv
// 16-bit Galois LFSR (taps 16'hB400). A load of zero would lock the register
// at zero forever, so a zero load value is replaced by the default seed.
module lfsr16
  import ga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] r_state;

  // Priority: reset, then seed load, then a single step when requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LFSR_SEED_DEFAULT;
    end else if (load) begin
      r_state <= (load_val == 16'h0000) ? LFSR_SEED_DEFAULT : load_val;
    end else if (step) begin
      r_state <= lfsr_advance(r_state);
    end
  end

  assign state = r_state;

endmodule

// File: rtl/inversion_point_gen.sv
// Inversion point generator: draws two distinct indices below CHROM_LEN from
// an LFSR and presents them ordered (idx_lo < idx_hi) to the inversion stage.
// Build option: define INVPT_SPAN_LIMIT_EN to reject pairs with hi-lo > MAX_SPAN.
//
// Handshake: a pair transfers on a rising edge where out_valid && out_ready.
// out_valid, idx_lo and idx_hi stay stable until that transfer; out_ready
// has no effect while out_valid is low. seed_load wins over a same-cycle
// transfer, which is then dropped.
module inversion_point_gen
  import ga_pkg::*;
#(
  parameter int CHROM_LEN = GA_CHROM_LEN,
  parameter int IDX_W     = GA_IDX_W,
  parameter int MAX_SPAN  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [15:0]      seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] idx_lo,
  output logic [IDX_W-1:0] idx_hi,
  output logic [15:0]      reject_cnt,
  output state_e           dbg_state,
  output logic [15:0]      dbg_lfsr
);

  state_e           r_state;
  logic [IDX_W-1:0] r_a;
  logic [IDX_W-1:0] r_b;
  logic [IDX_W-1:0] r_lo;
  logic [IDX_W-1:0] r_hi;
  logic [15:0]      r_rej;

  state_e           w_state_nxt;
  logic [15:0]      w_lfsr;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_lo;
  logic [IDX_W-1:0] w_hi;
  logic             w_in_range;
  logic             w_span_ok;
  logic             w_step;
  logic             w_take_a;
  logic             w_take_b;
  logic             w_take_pair;
  logic             w_reject;

  // The LFSR advances on every drawing cycle and freezes while a pair is held.
  assign w_step = (r_state != HOLD);

  lfsr16 u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load),
    .load_val (seed),
    .step     (w_step),
    .state    (w_lfsr)
  );

  assign w_cand     = w_lfsr[IDX_W-1:0];
  assign w_in_range = (int'(w_cand) < CHROM_LEN);
  assign w_lo       = (r_a < r_b) ? r_a : r_b;
  assign w_hi       = (r_a < r_b) ? r_b : r_a;

`ifdef INVPT_SPAN_LIMIT_EN
  assign w_span_ok = ((int'(w_hi) - int'(w_lo)) <= MAX_SPAN);
`else
  // Without span limiting every distinct pair is acceptable; MAX_SPAN is inert.
  logic w_unused_max_span;
  assign w_unused_max_span = (MAX_SPAN > 0);
  assign w_span_ok = 1'b1;
`endif

  // Next-state and draw decisions; a seed load aborts whatever was in progress.
  always_comb begin
    w_state_nxt = r_state;
    w_take_a    = 1'b0;
    w_take_b    = 1'b0;
    w_take_pair = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      DRAW_A: begin
        if (w_in_range) begin
          w_take_a    = 1'b1;
          w_state_nxt = DRAW_B;
        end else begin
          w_reject = 1'b1;
        end
      end
      DRAW_B: begin
        if (w_in_range && (w_cand != r_a)) begin
          w_take_b    = 1'b1;
          w_state_nxt = CHECK;
        end else begin
          w_reject = 1'b1;
        end
      end
      CHECK: begin
        if (w_span_ok) begin
          w_take_pair = 1'b1;
          w_state_nxt = HOLD;
        end else begin
          w_reject    = 1'b1;
          w_state_nxt = DRAW_A;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = DRAW_A;
        end
      end
      default: w_state_nxt = DRAW_A;
    endcase
    if (seed_load) begin
      w_state_nxt = DRAW_A;
      w_take_a    = 1'b0;
      w_take_b    = 1'b0;
      w_take_pair = 1'b0;
      w_reject    = 1'b0;
    end
  end

  // State, drawn indices, held output pair and saturating reject counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DRAW_A;
      r_a     <= '0;
      r_b     <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_rej   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take_a) begin
        r_a <= w_cand;
      end
      if (w_take_b) begin
        r_b <= w_cand;
      end
      if (w_take_pair) begin
        r_lo <= w_lo;
        r_hi <= w_hi;
      end
      if (w_reject && (r_rej != 16'hFFFF)) begin
        r_rej <= r_rej + 16'd1;
      end
    end
  end

  assign out_valid  = (r_state == HOLD);
  assign idx_lo     = r_lo;
  assign idx_hi     = r_hi;
  assign reject_cnt = r_rej;
  assign dbg_state  = r_state;
  assign dbg_lfsr   = w_lfsr;

endmodule

// File: tb/tb_inversion_point_gen.sv
// Directed bench for inversion_point_gen: hand-computed first pair after a
// zero seed, then a behavioural draw model for longer runs.
module tb_inversion_point_gen;
  import ga_pkg::*;

  localparam int IDX_W     = 8;
  localparam int CHROM_LEN = 150;
  localparam int MAX_SPAN  = 2;
  localparam int WAIT_MAX  = 20000;
`ifdef INVPT_SPAN_LIMIT_EN
  localparam int N_PAIRS   = 100;
`else
  localparam int N_PAIRS   = 2000;
`endif

  logic             clk;
  logic             rst;
  logic             seed_load;
  logic [15:0]      seed;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] idx_lo;
  logic [IDX_W-1:0] idx_hi;
  logic [15:0]      reject_cnt;
  state_e           dbg_state;
  logic [15:0]      dbg_lfsr;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0]  m_lfsr;
  int           m_rej;
  logic [15:0]  exp_q[$];

  inversion_point_gen #(
    .CHROM_LEN (CHROM_LEN),
    .IDX_W     (IDX_W),
    .MAX_SPAN  (MAX_SPAN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .seed       (seed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .idx_lo     (idx_lo),
    .idx_hi     (idx_hi),
    .reject_cnt (reject_cnt),
    .dbg_state  (dbg_state),
    .dbg_lfsr   (dbg_lfsr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic [15:0] t;
    t = {1'b0, s[15:1]};
    if (s[0]) t = t ^ 16'hB400;
    return t;
  endfunction

  // Behavioural draw model: walks m_lfsr from DRAW_A entry to the HOLD value.
  task automatic model_pair(output logic [IDX_W-1:0] lo, output logic [IDX_W-1:0] hi,
                            output int steps);
    logic [IDX_W-1:0] a;
    logic [IDX_W-1:0] b;
    bit done;
    done  = 1'b0;
    steps = 0;
    lo    = '0;
    hi    = '0;
    while (!done) begin
      while (int'(m_lfsr[IDX_W-1:0]) >= CHROM_LEN) begin
        m_lfsr = model_step(m_lfsr); m_rej++; steps++;
      end
      a = m_lfsr[IDX_W-1:0];
      m_lfsr = model_step(m_lfsr); steps++;
      while (int'(m_lfsr[IDX_W-1:0]) >= CHROM_LEN || m_lfsr[IDX_W-1:0] == a) begin
        m_lfsr = model_step(m_lfsr); m_rej++; steps++;
      end
      b = m_lfsr[IDX_W-1:0];
      m_lfsr = model_step(m_lfsr); steps++;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      m_lfsr = model_step(m_lfsr); steps++;
      done = 1'b1;
`ifdef INVPT_SPAN_LIMIT_EN
      if (int'(hi) - int'(lo) > MAX_SPAN) begin
        done = 1'b0;
        m_rej++;
      end
`endif
    end
  endtask

  // driver: from DRAW_A entry, wait for the pair and check it against the model
  task automatic wait_pair(output logic [IDX_W-1:0] lo, output logic [IDX_W-1:0] hi);
    int steps;
    int n;
    model_pair(lo, hi, steps);
    n = 0;
    while (out_valid !== 1'b1 && n < WAIT_MAX) begin
      tick();
      n++;
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pair_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
    end
    n_cmp++;
    if (n !== steps) begin
      n_fail++;
      $display("FAIL pair_latency: got %0d cycles, required %0d", n, steps);
    end
    n_cmp++;
    if (idx_lo !== lo || idx_hi !== hi) begin
      n_fail++;
      $display("FAIL pair_value: got lo=%0d hi=%0d, required lo=%0d hi=%0d", idx_lo, idx_hi, lo, hi);
    end
    n_cmp++;
    if (!(idx_lo < idx_hi && int'(idx_hi) <= CHROM_LEN - 1)) begin
      n_fail++;
      $display("FAIL pair_order: got lo=%0d hi=%0d, required lo<hi<=%0d", idx_lo, idx_hi, CHROM_LEN - 1);
    end
    n_cmp++;
    if (reject_cnt !== 16'(m_rej)) begin
      n_fail++;
      $display("FAIL reject_cnt: got %0d, required %0d", reject_cnt, m_rej);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; seed_load = 1'b0; seed = 16'h0; out_ready = 1'b0;
    tick();
    seed_load = 1'b1; seed = 16'h1234;   // reset must override the load
    tick();
    seed_load = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || idx_lo !== '0 || idx_hi !== '0 || reject_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b lo=%0d hi=%0d rej=%0d, required 0 0 0 0",
               out_valid, idx_lo, idx_hi, reject_cnt);
    end
    n_cmp++;
    if (dbg_lfsr !== 16'hACE1 || dbg_state !== DRAW_A) begin
      n_fail++;
      $display("FAIL reset_state: got lfsr=%h state=%0d, required ace1 0", dbg_lfsr, dbg_state);
    end
  endtask

  // Hand trace from ACE1: ACE1(225 rej) -> E270(a=112) -> 7138(b=56) -> 389C(check) -> 1C4E
  task automatic test_seed_zero();
    int n;
    rst = 1'b0; seed_load = 1'b1; seed = 16'h0000;
    tick();
    seed_load = 1'b0;
    n_cmp++;
    if (dbg_lfsr !== 16'hACE1 || dbg_state !== DRAW_A || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL seed_zero_load: got lfsr=%h state=%0d v=%b, required ace1 0 0",
               dbg_lfsr, dbg_state, out_valid);
    end
    tick();
    n_cmp++;
    if (dbg_lfsr !== 16'hE270 || reject_cnt !== 16'd1 || dbg_state !== DRAW_A) begin
      n_fail++;
      $display("FAIL first_reject: got lfsr=%h rej=%0d state=%0d, required e270 1 0",
               dbg_lfsr, reject_cnt, dbg_state);
    end
    n = 1;
    while (out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL first_latency: got %0d cycles, required 4", n);
    end
    n_cmp++;
    if (idx_lo !== 8'd56 || idx_hi !== 8'd112 || dbg_lfsr !== 16'h1C4E) begin
      n_fail++;
      $display("FAIL first_pair: got lo=%0d hi=%0d lfsr=%h, required 56 112 1c4e",
               idx_lo, idx_hi, dbg_lfsr);
    end
    m_lfsr = 16'h1C4E;
    m_rej  = 1;
    consume();
  endtask

  task automatic test_back_to_back();
    logic [IDX_W-1:0] lo;
    logic [IDX_W-1:0] hi;
    int max_span;
    max_span = 0;
    out_ready = 1'b1;
    for (int i = 0; i < N_PAIRS; i++) begin
      wait_pair(lo, hi);
      if (int'(idx_hi) - int'(idx_lo) > max_span) max_span = int'(idx_hi) - int'(idx_lo);
`ifdef INVPT_SPAN_LIMIT_EN
      n_cmp++;
      if (int'(idx_hi) - int'(idx_lo) < 1 || int'(idx_hi) - int'(idx_lo) > MAX_SPAN) begin
        n_fail++;
        $display("FAIL span_limit: got span %0d, required 1..%0d", int'(idx_hi) - int'(idx_lo), MAX_SPAN);
      end
`endif
      consume();
    end
`ifndef INVPT_SPAN_LIMIT_EN
    n_cmp++;
    if (max_span <= 2) begin
      n_fail++;
      $display("FAIL span_unlimited: got max span %0d, required > 2", max_span);
    end
`endif
  endtask

  task automatic test_hold_stall();
    logic [IDX_W-1:0] lo;
    logic [IDX_W-1:0] hi;
    out_ready = 1'b0;
    wait_pair(lo, hi);
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || idx_lo !== lo || idx_hi !== hi || dbg_lfsr !== m_lfsr) begin
        n_fail++;
        $display("FAIL hold_stall[%0d]: got v=%b lo=%0d hi=%0d lfsr=%h, required 1 %0d %0d %h",
                 i, out_valid, idx_lo, idx_hi, dbg_lfsr, lo, hi, m_lfsr);
      end
    end
    consume();
  endtask

  task automatic test_seed_handshake();
    logic [IDX_W-1:0] lo;
    logic [IDX_W-1:0] hi;
    out_ready = 1'b0;
    wait_pair(lo, hi);
    out_ready = 1'b1; seed_load = 1'b1; seed = 16'h5555;
    tick();
    seed_load = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || dbg_state !== DRAW_A || dbg_lfsr !== 16'h5555 ||
        reject_cnt !== 16'(m_rej)) begin
      n_fail++;
      $display("FAIL seed_vs_handshake: got v=%b state=%0d lfsr=%h rej=%0d, required 0 0 5555 %0d",
               out_valid, dbg_state, dbg_lfsr, reject_cnt, m_rej);
    end
    m_lfsr = 16'h5555;
    out_ready = 1'b1;
    wait_pair(lo, hi);
    consume();
  endtask

  task automatic test_reset_mid_hold();
    logic [IDX_W-1:0] lo;
    logic [IDX_W-1:0] hi;
    out_ready = 1'b0;
    wait_pair(lo, hi);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || idx_lo !== '0 || idx_hi !== '0 || reject_cnt !== 16'h0 ||
        dbg_lfsr !== 16'hACE1 || dbg_state !== DRAW_A) begin
      n_fail++;
      $display("FAIL reset_mid_hold: got v=%b lo=%0d hi=%0d rej=%0d lfsr=%h state=%0d, required 0 0 0 0 ace1 0",
               out_valid, idx_lo, idx_hi, reject_cnt, dbg_lfsr, dbg_state);
    end
  endtask

  task automatic test_seed_repeat();
    logic [IDX_W-1:0] lo;
    logic [IDX_W-1:0] hi;
    logic [15:0] exp_pair;
    for (int rep = 0; rep < 2; rep++) begin
      rst = 1'b1; out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0; seed_load = 1'b1; seed = 16'h1234;
      tick();
      seed_load = 1'b0;
      n_cmp++;
      if (dbg_lfsr !== 16'h1234 || reject_cnt !== 16'h0) begin
        n_fail++;
        $display("FAIL seed_1234_load: got lfsr=%h rej=%0d, required 1234 0", dbg_lfsr, reject_cnt);
      end
      m_lfsr = 16'h1234;
      m_rej  = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
        wait_pair(lo, hi);
        if (rep == 0) begin
          exp_q.push_back({idx_lo, idx_hi});
        end else if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL seed_repeat[%0d]: got lo=%0d hi=%0d, required a queued pair", i, idx_lo, idx_hi);
        end else begin
          exp_pair = exp_q.pop_front();
          n_cmp++;
          if ({idx_lo, idx_hi} !== exp_pair) begin
            n_fail++;
            $display("FAIL seed_repeat[%0d]: got %h, required %h", i, {idx_lo, idx_hi}, exp_pair);
          end
        end
        consume();
      end
    end
  endtask

  initial begin
    rst = 1'b1; seed_load = 1'b0; seed = 16'h0; out_ready = 1'b0;
    m_lfsr = 16'hACE1;
    m_rej  = 0;
    test_reset();
    test_seed_zero();
    test_back_to_back();
    test_hold_stall();
    test_seed_handshake();
    test_reset_mid_hold();
    test_seed_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
